tdc_digital: RTL and testbench
==============================

Name: tdc_digital

Overview:
- Digital back end of the ADPLL time-to-digital converter. It is the consumer of the analog TDC outputs `tdc_ripple_count` and `tdc_phase`, and the producer of the 12-bit `tdc_word` used by the loop filter.
- On every `clk` rising edge it captures the DCO edge counter and the 16-tap phase vector, bubble-corrects and decodes the phase into a fractional period, and concatenates the two into `tdc_word`.
- It also outputs the word-to-word difference (frequency estimate), an invalid-code error count, and the analog TDC power-down control.

Parameters:
- CNT_W, 7, width of ripple counter input.
- PHASE_W, 16, number of TDC delay taps (half DCO period).
- FRAC_W, 5, fractional width; equals log2(PHASE_W)+1.
- WORD_W, 12, output word width; equals CNT_W+FRAC_W.
- ERR_W, 8, width of saturating error counter.
- WARM_CYC, 4, clk cycles the analog TDC settles after power-up.

Ports:
- clk  in  1  reference clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enable; low requests power-down.
- tdc_ripple_count  in  CNT_W  DCO edge counter from analog TDC.
- tdc_phase  in  PHASE_W  thermometer tap snapshot; bit 0 is the earliest tap.
- tdc_pd  out  1  analog TDC power-down.
- tdc_word  out  WORD_W  {count, frac}.
- tdc_word_valid  out  1  tdc_word is meaningful this cycle.
- tdc_diff  out  WORD_W  tdc_word minus previous valid tdc_word, mod 2^WORD_W.
- tdc_diff_valid  out  1  tdc_diff is meaningful.
- err_count  out  ERR_W  saturating count of invalid phase codes.

Behaviour:
- Reset: all registers 0, except tdc_pd = 1. State goes to OFF. Reset mid-operation aborts immediately and does not preserve err_count.
- FSM:
  - OFF: tdc_pd = 1. `en` = 1 at an edge moves to WARMUP, with tdc_pd = 0 from that edge.
  - WARMUP: count WARM_CYC cycles, then go to FILL.
  - FILL: 3 cycles, then go to RUN.
  - RUN: steady state.
  - From any state, `en` = 0 at an edge moves to OFF. tdc_pd, tdc_word_valid and tdc_diff_valid are updated on that same edge. tdc_word and tdc_diff hold their last values.
- Pipeline (3 stages, active in FILL and RUN):
  - S1: register raw count and phase.
  - S2: optional bubble correction, then edge search.
  - S3: output registers.
  - Latency: inputs at edge N appear on outputs after edge N+3.
  - First tdc_word_valid = 1 occurs WARM_CYC+3 edges after `en` is sampled high.
- Decode:
  - k = smallest i in 1..PHASE_W-1 with phase[i] != phase[0].
  - frac = phase[0] ? k : PHASE_W + k, giving a range of 1..31.
  - tdc_word = {count, frac[FRAC_W-1:0]}, using the count from the same S1 sample.
- Invalid code:
  - An invalid code is either no transition (all taps equal) or more than one transition after correction.
  - No transition: frac holds its previous decoded value; count updates normally.
  - More than one transition: decode uses the first transition.
  - Both cases increment err_count, which saturates at 2^ERR_W-1 and does not wrap. err_count also updates during FILL.
- Diff:
  - tdc_diff = tdc_word - previous valid tdc_word, as unsigned modulo 2^WORD_W; wrap-around of the ripple counter is therefore handled naturally.
  - tdc_diff_valid rises one valid word after tdc_word_valid, i.e. from the second valid word onwards.
  - Leaving RUN clears the previous-word-valid flag.

Optional Feature:
- Macro: TDC_BUBBLE_CORR_EN.
- Defined: in S2, phase_c[i] = majority(phase[i-1], phase[i], phase[i+1]) for i = 1..PHASE_W-2; bits 0 and PHASE_W-1 pass through unchanged. The edge search uses phase_c.
- Undefined: the raw phase is decoded. Single-tap bubbles count as multiple transitions and increment err_count.

Decomposition:
- Package tdc_pkg:
  - CNT_W, PHASE_W, FRAC_W and WORD_W defaults.
  - State enum: OFF, WARMUP, FILL, RUN.
  - A function for first-transition index and transition count.
- Sub-module tdc_therm_decode: combinational bubble correction plus edge search, returning {k, n_transitions}. Instantiated in S2.

Test Plan:
- Reset: hold rst_n low -> tdc_pd = 1, all other outputs 0. Release with en = 0 -> unchanged after 10 cycles.
- Power-up: assert en at edge N -> tdc_pd = 0 at N; tdc_word_valid first high after edge N+7; tdc_diff_valid first high after edge N+8.
- Decode:
  - count = 7'h25, phase = 16'h00FF -> k = 8, tdc_word = 12'h4A8, three cycles later.
  - count = 7'h10, phase = 16'hFFF0 -> frac = 20, tdc_word = 12'h214.
- Wrap: word 12'hFFF (count 127, frac 31), then count 0 with phase = 16'hFFF8 (frac = 19) -> tdc_word = 12'h013, tdc_diff = 12'h014.
- Bubble: phase = 16'h00F7:
  - With TDC_BUBBLE_CORR_EN -> frac = 8, err_count unchanged.
  - Without it -> frac = 3, err_count +1.
- Invalid/disable:
  - phase = 16'hFFFF -> frac held, err_count +1.
  - 300 invalid codes -> err_count = 255.
  - en dropped in RUN -> both valids = 0 and tdc_pd = 1 on the next edge.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared widths, FSM state encoding and thermometer edge-search helper
// for the ADPLL TDC digital back end.
package tdc_pkg;

  localparam int unsigned CNT_W        = 7;
  localparam int unsigned PHASE_W      = 16;
  localparam int unsigned FRAC_W       = 5;
  localparam int unsigned WORD_W       = CNT_W + FRAC_W;
  localparam int unsigned ERR_W        = 8;
  localparam int unsigned WARM_CYC_DEF = 4;
  localparam int unsigned K_W          = FRAC_W - 1;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    WARMUP = 2'd1,
    FILL   = 2'd2,
    RUN    = 2'd3
  } tdc_state_e;

  typedef struct packed {
    logic [K_W-1:0] k;
    logic [K_W-1:0] n;
  } tdc_edge_t;

  // k = first tap differing from tap 0 (0 when none), n = number of transitions
  function automatic tdc_edge_t tdc_edge_search(input logic [PHASE_W-1:0] ph);
    tdc_edge_t r;
    r.k = {K_W{1'b0}};
    r.n = {K_W{1'b0}};
    for (int i = PHASE_W - 1; i >= 1; i--) begin
      if (ph[i] != ph[0]) begin
        r.k = i[K_W-1:0];
      end
    end
    for (int i = 1; i < PHASE_W; i++) begin
      if (ph[i] != ph[i-1]) begin
        r.n = r.n + K_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tdc_digital_if.sv
// Signal bundle between the analog TDC / loop filter side and tdc_digital.
interface tdc_digital_if;
  import tdc_pkg::*;

  logic                en;
  logic [CNT_W-1:0]    tdc_ripple_count;
  logic [PHASE_W-1:0]  tdc_phase;
  logic                tdc_pd;
  logic [WORD_W-1:0]   tdc_word;
  logic                tdc_word_valid;
  logic [WORD_W-1:0]   tdc_diff;
  logic                tdc_diff_valid;
  logic [ERR_W-1:0]    err_count;

  modport master (
    output en, tdc_ripple_count, tdc_phase,
    input  tdc_pd, tdc_word, tdc_word_valid, tdc_diff, tdc_diff_valid, err_count
  );

  modport slave (
    input  en, tdc_ripple_count, tdc_phase,
    output tdc_pd, tdc_word, tdc_word_valid, tdc_diff, tdc_diff_valid, err_count
  );

endinterface

// File: rtl/tdc_therm_decode.sv
// Combinational thermometer decode: optional 3-tap majority bubble filter
// (TDC_BUBBLE_CORR_EN) followed by first-edge search and transition count.
module tdc_therm_decode
  import tdc_pkg::*;
(
  input  logic [PHASE_W-1:0] phase_i,
  output logic [K_W-1:0]     k_o,
  output logic [K_W-1:0]     n_o
);

  logic [PHASE_W-1:0] phase_c_s;
  tdc_edge_t          edge_s;

`ifdef TDC_BUBBLE_CORR_EN
  // End taps have only one neighbour, so they pass through unfiltered
  always_comb begin
    phase_c_s = phase_i;
    for (int i = 1; i < PHASE_W - 1; i++) begin
      phase_c_s[i] = (phase_i[i-1] & phase_i[i]) |
                     (phase_i[i]   & phase_i[i+1]) |
                     (phase_i[i-1] & phase_i[i+1]);
    end
  end
`else
  assign phase_c_s = phase_i;
`endif

  assign edge_s = tdc_edge_search(phase_c_s);
  assign k_o    = edge_s.k;
  assign n_o    = edge_s.n;

endmodule

// File: rtl/tdc_digital.sv
// TDC digital back end: power sequencing FSM, 3-stage capture/decode/output
// pipeline, word difference and saturating invalid-code counter.
// Optional bubble correction is selected with TDC_BUBBLE_CORR_EN.
module tdc_digital
  import tdc_pkg::*;
#(
  parameter int unsigned WARM_CYC = WARM_CYC_DEF
) (
  input logic          clk,
  input logic          rst_n,
  tdc_digital_if.slave bus
);

  localparam int unsigned      SEQ_W     = (WARM_CYC > 3) ? $clog2(WARM_CYC) : 2;
  localparam logic [SEQ_W-1:0] WARM_LAST = SEQ_W'(WARM_CYC - 1);
  localparam logic [SEQ_W-1:0] FILL_LAST = SEQ_W'(2);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  tdc_state_e         state_q, state_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               pd_q, pd_d;
  logic               active_s;

  logic [CNT_W-1:0]   s1_cnt_q;
  logic [PHASE_W-1:0] s1_ph_q;
  logic               s1_vld_q;
  logic [K_W-1:0]     dec_k_s, dec_n_s;
  logic [CNT_W-1:0]   s2_cnt_q;
  logic [K_W-1:0]     s2_k_q, s2_n_q;
  logic               s2_ph0_q, s2_vld_q;

  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               word_vld_q, word_vld_d;
  logic [WORD_W-1:0]  diff_q, diff_d;
  logic               diff_vld_q, diff_vld_d;
  logic               prev_vld_q, prev_vld_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               bad_s;

  // Power sequencing; en low overrides every state on the same edge
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    case (state_q)
      OFF: begin
        if (bus.en) begin
          state_d = WARMUP;
          seq_d   = {SEQ_W{1'b0}};
        end else begin
          state_d = OFF;
        end
      end
      WARMUP: begin
        if (seq_q == WARM_LAST) begin
          state_d = FILL;
          seq_d   = {SEQ_W{1'b0}};
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      FILL: begin
        if (seq_q == FILL_LAST) begin
          state_d = RUN;
          seq_d   = {SEQ_W{1'b0}};
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = OFF;
    endcase
    if (!bus.en) begin
      state_d = OFF;
      seq_d   = {SEQ_W{1'b0}};
    end else begin
      seq_d = seq_d;
    end
    pd_d = (state_d == OFF);
  end

  // FSM state and power-down register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      seq_q   <= {SEQ_W{1'b0}};
      pd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      pd_q    <= pd_d;
    end
  end

  assign active_s = bus.en & ((state_q == FILL) | (state_q == RUN));

  tdc_therm_decode u_decode (
    .phase_i (s1_ph_q),
    .k_o     (dec_k_s),
    .n_o     (dec_n_s)
  );

  // S1 raw capture and S2 decoded edge; data holds while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_cnt_q <= {CNT_W{1'b0}};
      s1_ph_q  <= {PHASE_W{1'b0}};
      s1_vld_q <= 1'b0;
      s2_cnt_q <= {CNT_W{1'b0}};
      s2_k_q   <= {K_W{1'b0}};
      s2_n_q   <= {K_W{1'b0}};
      s2_ph0_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= active_s;
      s2_vld_q <= active_s & s1_vld_q;
      if (active_s) begin
        s1_cnt_q <= bus.tdc_ripple_count;
        s1_ph_q  <= bus.tdc_phase;
        s2_cnt_q <= s1_cnt_q;
        s2_k_q   <= dec_k_s;
        s2_n_q   <= dec_n_s;
        s2_ph0_q <= s1_ph_q[0];
      end
    end
  end

  assign bad_s = (s2_n_q == {K_W{1'b0}}) | (s2_n_q > K_W'(1));

  // S3: no-edge codes keep the last fraction; word_q doubles as the previous word
  always_comb begin
    frac_d     = frac_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    diff_d     = diff_q;
    diff_vld_d = 1'b0;
    prev_vld_d = prev_vld_q;
    err_d      = err_q;
    if (!active_s) begin
      prev_vld_d = 1'b0;
    end else if (s2_vld_q) begin
      if (s2_n_q != {K_W{1'b0}}) begin
        frac_d = s2_ph0_q ? {1'b0, s2_k_q} : (FRAC_W'(PHASE_W) + {1'b0, s2_k_q});
      end else begin
        frac_d = frac_q;
      end
      word_d     = {s2_cnt_q, frac_d};
      word_vld_d = 1'b1;
      prev_vld_d = 1'b1;
      if (prev_vld_q) begin
        diff_d     = word_d - word_q;
        diff_vld_d = 1'b1;
      end else begin
        diff_d     = diff_q;
        diff_vld_d = 1'b0;
      end
      if (bad_s && (err_q != ERR_MAX)) begin
        err_d = err_q + ERR_W'(1);
      end else begin
        err_d = err_q;
      end
    end else begin
      prev_vld_d = prev_vld_q;
    end
  end

  // S3 output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frac_q     <= {FRAC_W{1'b0}};
      word_q     <= {WORD_W{1'b0}};
      word_vld_q <= 1'b0;
      diff_q     <= {WORD_W{1'b0}};
      diff_vld_q <= 1'b0;
      prev_vld_q <= 1'b0;
      err_q      <= {ERR_W{1'b0}};
    end else begin
      frac_q     <= frac_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      diff_q     <= diff_d;
      diff_vld_q <= diff_vld_d;
      prev_vld_q <= prev_vld_d;
      err_q      <= err_d;
    end
  end

  assign bus.tdc_pd         = pd_q;
  assign bus.tdc_word       = word_q;
  assign bus.tdc_word_valid = word_vld_q;
  assign bus.tdc_diff       = diff_q;
  assign bus.tdc_diff_valid = diff_vld_q;
  assign bus.err_count      = err_q;

endmodule

// File: tb/tb_tdc_digital.sv
// Self-checking bench for tdc_digital: vector table plus scoreboard queue,
// with hand-written power-up, saturation, disable and mid-run reset sequences.
module tb_tdc_digital;
  import tdc_pkg::*;

  localparam int WARM = 4;

  typedef struct {
    logic [6:0]  cnt;
    logic [15:0] ph;
    logic [4:0]  frac;   // 0 = no edge, fraction expected to hold
    logic        bad;
  } vec_t;

  typedef struct {
    logic [11:0] word;
    logic [11:0] diff;
    logic        dvld;
    logic [7:0]  err;
    int          appear;
  } rec_t;

  logic clk;
  logic rst_n;
  tdc_digital_if bus ();

  tdc_digital dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t        tbl [12];
  rec_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          edge_n = 0;
  int          en_edges = 0;
  logic [4:0]  last_frac = 5'd0;
  logic [11:0] prev_word = 12'd0;
  logic        prev_vld = 1'b0;
  logic [7:0]  err_m = 8'd0;
  logic [11:0] shown_word = 12'd0;
  logic [11:0] shown_diff = 12'd0;
  logic        shown_dvld = 1'b0;
  logic [7:0]  shown_err = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic check_outputs();
    rec_t r;
    logic exp_v;
    while (sb.size() > 0 && sb[0].appear < edge_n) r = sb.pop_front();
    exp_v = (sb.size() > 0) && (sb[0].appear == edge_n);
    chk("pd", 32'(bus.tdc_pd), 32'(en_edges == 0));
    chk("word_valid", 32'(bus.tdc_word_valid), 32'(exp_v));
    if (exp_v) begin
      r          = sb.pop_front();
      shown_word = r.word;
      shown_err  = r.err;
      shown_dvld = r.dvld;
      if (r.dvld) shown_diff = r.diff;
    end else begin
      shown_dvld = 1'b0;
    end
    chk("word", 32'(bus.tdc_word), 32'(shown_word));
    chk("diff_valid", 32'(bus.tdc_diff_valid), 32'(shown_dvld));
    chk("diff", 32'(bus.tdc_diff), 32'(shown_diff));
    chk("err_count", 32'(bus.err_count), 32'(shown_err));
  endtask

  task automatic reset_model();
    sb.delete();
    en_edges   = 0;
    last_frac  = 5'd0;
    prev_word  = 12'd0;
    prev_vld   = 1'b0;
    err_m      = 8'd0;
    shown_word = 12'd0;
    shown_diff = 12'd0;
    shown_dvld = 1'b0;
    shown_err  = 8'd0;
  endtask

  // Drive one input sample, advance one clock and check the outputs
  task automatic drive_cycle(input logic [6:0] c, input logic [15:0] p,
                             input logic [4:0] f, input logic bad);
    rec_t r;
    logic [4:0] fe;
    bus.tdc_ripple_count = c;
    bus.tdc_phase        = p;
    @(posedge clk);
    edge_n++;
    if (rst_n && !bus.en) begin
      en_edges = 0;
      prev_vld = 1'b0;
      sb.delete();
    end else if (rst_n && bus.en) begin
      en_edges++;
      if (en_edges >= WARM + 2) begin
        fe        = (f == 5'd0) ? last_frac : f;
        last_frac = fe;
        r.word    = {c, fe};
        r.diff    = r.word - prev_word;
        r.dvld    = prev_vld;
        if (bad && err_m != 8'hFF) err_m = err_m + 8'd1;
        r.err     = err_m;
        r.appear  = edge_n + 2;
        prev_word = r.word;
        prev_vld  = 1'b1;
        sb.push_back(r);
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    tbl[0]  = '{7'h25, 16'h00FF, 5'd8,  1'b0};
    tbl[1]  = '{7'h10, 16'hFFF0, 5'd20, 1'b0};
    tbl[2]  = '{7'h7F, 16'h8000, 5'd31, 1'b0};
    tbl[3]  = '{7'h00, 16'hFFF8, 5'd19, 1'b0};
    tbl[4]  = '{7'h12, 16'hFFFF, 5'd0,  1'b1};
    tbl[5]  = '{7'h12, 16'h0000, 5'd0,  1'b1};
`ifdef TDC_BUBBLE_CORR_EN
    tbl[6]  = '{7'h33, 16'h00F7, 5'd8,  1'b0};
`else
    tbl[6]  = '{7'h33, 16'h00F7, 5'd3,  1'b1};
`endif
    tbl[7]  = '{7'h01, 16'h0001, 5'd1,  1'b0};
    tbl[8]  = '{7'h40, 16'hFFFE, 5'd17, 1'b0};
    tbl[9]  = '{7'h05, 16'h7FFF, 5'd15, 1'b0};
    tbl[10] = '{7'h05, 16'h0F0F, 5'd4,  1'b1};
    tbl[11] = '{7'h6A, 16'h0003, 5'd2,  1'b0};

    rst_n                = 1'b0;
    bus.en               = 1'b0;
    bus.tdc_ripple_count = 7'd0;
    bus.tdc_phase        = 16'd0;
    reset_model();

    repeat (3) drive_cycle(7'd0, 16'd0, 5'd0, 1'b0);
    rst_n = 1'b1;
    repeat (10) drive_cycle(7'd0, 16'd0, 5'd0, 1'b0);

    // Power-up with a steady filler code, then the decode table
    bus.en = 1'b1;
    repeat (9) drive_cycle(7'd0, 16'h00FF, 5'd8, 1'b0);
    for (int i = 0; i < 12; i++) drive_cycle(tbl[i].cnt, tbl[i].ph, tbl[i].frac, tbl[i].bad);

    for (int i = 0; i < 300; i++) drive_cycle(7'(i), 16'hFFFF, 5'd0, 1'b1);
    repeat (2) drive_cycle(7'h11, 16'h00FF, 5'd8, 1'b0);
    chk("err_saturated", 32'(bus.err_count), 32'hFF);

    // Drop en in RUN: valids and pd change on the next edge, data holds
    bus.en = 1'b0;
    repeat (3) drive_cycle(7'h22, 16'h00FF, 5'd8, 1'b0);

    // Re-enable: diff_valid must restart from the second word
    bus.en = 1'b1;
    repeat (10) drive_cycle(7'h03, 16'h003F, 5'd6, 1'b0);

    // Asynchronous reset mid-run clears everything including err_count
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_outputs();
    bus.en = 1'b0;
    repeat (2) drive_cycle(7'd0, 16'd0, 5'd0, 1'b0);
    rst_n = 1'b1;
    repeat (2) drive_cycle(7'd0, 16'd0, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
